// File: rtl/rob.sv
// Reorder buffer: 7-entry in-order retire queue with a register alias table,
// operand lookup toward the reservation station, and an architectural regfile.
// Tags 1..7 name the entries directly; tag 0 means "no producer / no broadcast".
module rob (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [5:0]  issue_op,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        rs_full,
    input  logic [31:0] alu_data,
    input  logic [2:0]  alu_des_in,
    input  logic [31:0] memory_data,
    input  logic [2:0]  memory_des_in,
    input  logic        flush,
    output logic        issue_accept,
    output logic [2:0]  issue_tag,
    output logic [31:0] value1,
    output logic [31:0] value2,
    output logic [2:0]  query1,
    output logic [2:0]  query2,
    output logic        rob_full,
    output logic        commit_valid,
    output logic [2:0]  commit_tag,
    output logic [4:0]  commit_rd,
    output logic [31:0] commit_data
);

    typedef struct packed {
        logic [31:0] val;
        logic [2:0]  q;
    } operand_t;

    // Slot 0 exists only so tags index the arrays directly; it is never allocated.
    logic [7:0]  busy;
    logic [7:0]  ready;
    logic [5:0]  ent_op  [8];
    logic [4:0]  ent_rd  [8];
    logic [31:0] ent_val [8];
    logic [2:0]  rat     [32];
    logic [31:0] regfile [32];
    logic [2:0]  head;
    logic [2:0]  tail;
    logic [2:0]  count;

    logic        commit_fire;
    logic [4:0]  issue_rd_eff;
    operand_t    op1;
    operand_t    op2;

    // Branches and stores produce no register result.
    function automatic logic has_dest(input logic [5:0] op);
        return !((op >= 6'd10 && op <= 6'd13) || (op >= 6'd23 && op <= 6'd27));
    endfunction

    function automatic logic [2:0] next_tag(input logic [2:0] t);
        return (t == 3'd7) ? 3'd1 : t + 3'd1;
    endfunction

    // Uses the pre-issue mapping, so a source equal to the issuing rd sees the
    // older producer. Memory broadcast is checked first so it wins a tag tie.
    function automatic operand_t lookup(input logic [4:0] rs);
        operand_t   r;
        logic [2:0] t;
        r = '0;
        t = rat[rs];
        if (rs != 5'd0) begin
            if (t == 3'd0)                r.val = regfile[rs];
            else if (ready[t])            r.val = ent_val[t];
            else if (memory_des_in == t)  r.val = memory_data;
            else if (alu_des_in == t)     r.val = alu_data;
            else                          r.q   = t;
        end
        return r;
    endfunction

    // Issue handshake, retire decision and operand lookup.
    always_comb begin
        rob_full     = (count == 3'd7);
        issue_accept = issue_valid & ~rob_full & ~rs_full & ~flush;
        issue_tag    = tail;
        issue_rd_eff = has_dest(issue_op) ? issue_rd : 5'd0;
        commit_fire  = busy[head] & ready[head];
        op1          = lookup(issue_rs1);
        op2          = lookup(issue_rs2);
        value1       = op1.val;
        query1       = op1.q;
        value2       = op2.val;
        query2       = op2.q;
    end

    // State update: flush beats everything; within a normal cycle the issue
    // rename is written last so it overrides a same-cycle commit clear of rat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            ready <= '0;
            for (int i = 0; i < 8; i++) begin
                ent_op[i]  <= '0;
                ent_rd[i]  <= '0;
                ent_val[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                rat[i]     <= '0;
                regfile[i] <= '0;
            end
            head         <= 3'd1;
            tail         <= 3'd1;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else if (flush) begin
            busy  <= '0;
            ready <= '0;
            for (int i = 0; i < 32; i++) rat[i] <= '0;
            head         <= 3'd1;
            tail         <= 3'd1;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= commit_fire;
            commit_tag   <= commit_fire ? head : 3'd0;
            commit_rd    <= commit_fire ? ent_rd[head] : 5'd0;
            commit_data  <= commit_fire ? ent_val[head] : 32'd0;

            if (alu_des_in != 3'd0 && busy[alu_des_in]) begin
                ready[alu_des_in]   <= 1'b1;
                ent_val[alu_des_in] <= alu_data;
            end
            if (memory_des_in != 3'd0 && busy[memory_des_in]) begin
                ready[memory_des_in]   <= 1'b1;
                ent_val[memory_des_in] <= memory_data;
            end

            if (commit_fire) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                if (has_dest(ent_op[head]) && ent_rd[head] != 5'd0)
                    regfile[ent_rd[head]] <= ent_val[head];
                if (ent_rd[head] != 5'd0 && rat[ent_rd[head]] == head)
                    rat[ent_rd[head]] <= 3'd0;
                head <= next_tag(head);
            end

            if (issue_accept) begin
                busy[tail]   <= 1'b1;
                ready[tail]  <= 1'b0;
                ent_op[tail] <= issue_op;
                ent_rd[tail] <= issue_rd_eff;
                if (issue_rd_eff != 5'd0) rat[issue_rd_eff] <= tail;
                tail <= next_tag(tail);
            end

            count <= count + {2'b00, issue_accept} - {2'b00, commit_fire};
        end
    end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus a randomized run checked against an
// in-order queue model (youngest in-flight writer of a register = its producer).
module tb_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  issue_op;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        rs_full;
    logic [31:0] alu_data, memory_data;
    logic [2:0]  alu_des_in, memory_des_in;
    logic        flush;
    logic        issue_accept;
    logic [2:0]  issue_tag;
    logic [31:0] value1, value2;
    logic [2:0]  query1, query2;
    logic        rob_full;
    logic        commit_valid;
    logic [2:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;

    int n_tests = 0;
    int n_fail  = 0;

    rob dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .rs_full(rs_full), .alu_data(alu_data), .alu_des_in(alu_des_in),
        .memory_data(memory_data), .memory_des_in(memory_des_in), .flush(flush),
        .issue_accept(issue_accept), .issue_tag(issue_tag),
        .value1(value1), .value2(value2), .query1(query1), .query2(query2),
        .rob_full(rob_full), .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_rd(commit_rd), .commit_data(commit_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_rf [32];
    logic [2:0]  m_tail;
    logic        m_cv;
    logic [2:0]  m_ctag;
    logic [4:0]  m_crd;
    logic [31:0] m_cdata;

    function automatic bit no_dest(input logic [5:0] op);
        return (op >= 10 && op <= 13) || (op >= 23 && op <= 27);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_tail = 1; m_cv = 0; m_ctag = 0; m_crd = 0; m_cdata = 0;
    endtask

    task automatic m_lookup(input logic [4:0] rs, output logic [31:0] v, output logic [2:0] q);
        v = 0; q = 0;
        if (rs == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
                if (mq[i].rdy)                       v = mq[i].val;
                else if (memory_des_in == mq[i].tag) v = memory_data;
                else if (alu_des_in == mq[i].tag)    v = alu_data;
                else                                 q = mq[i].tag;
                return;
            end
        end
        v = m_rf[rs];
    endtask

    function automatic bit m_accept();
        return issue_valid && mq.size() < 7 && !rs_full && !flush;
    endfunction

    // Apply the coming posedge to the model, then wait for the next negedge.
    task automatic adv();
        bit acc;
        ent_t e;
        acc = m_accept();
        if (flush) begin
            mq.delete();
            m_tail = 1; m_cv = 0; m_ctag = 0; m_crd = 0; m_cdata = 0;
        end else begin
            if (mq.size() > 0 && mq[0].rdy) begin
                m_cv = 1; m_ctag = mq[0].tag; m_crd = mq[0].rd; m_cdata = mq[0].val;
                if (mq[0].rd != 0) m_rf[mq[0].rd] = mq[0].val;
                void'(mq.pop_front());
            end else begin
                m_cv = 0; m_ctag = 0; m_crd = 0; m_cdata = 0;
            end
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (memory_des_in != 0 && memory_des_in == e.tag) begin e.rdy = 1; e.val = memory_data; end
                else if (alu_des_in != 0 && alu_des_in == e.tag) begin e.rdy = 1; e.val = alu_data; end
                mq[i] = e;
            end
            if (acc) begin
                e.tag = m_tail; e.rd = no_dest(issue_op) ? 5'd0 : issue_rd; e.rdy = 0; e.val = 0;
                mq.push_back(e);
                m_tail = (m_tail == 7) ? 3'd1 : m_tail + 3'd1;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_valid = 0; issue_op = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        rs_full = 0; alu_data = 0; alu_des_in = 0; memory_data = 0; memory_des_in = 0; flush = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        idle();
        issue_valid = 1; issue_op = op; issue_rd = rd; issue_rs1 = s1; issue_rs2 = s2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1;
        issue_rs1 = 3;
        #1;
        n_tests++;
        if ({commit_valid, commit_tag, commit_rd, commit_data} !== 41'd0) begin
            n_fail++; $display("FAIL reset_commit got v=%0d t=%0d rd=%0d d=%h exp all 0", commit_valid, commit_tag, commit_rd, commit_data);
        end
        n_tests++;
        if (rob_full !== 0 || issue_tag !== 3'd1) begin
            n_fail++; $display("FAIL reset_state got full=%0d tag=%0d exp full=0 tag=1", rob_full, issue_tag);
        end
        n_tests++;
        if (value1 !== 0 || query1 !== 0) begin
            n_fail++; $display("FAIL reset_lookup got v=%h q=%0d exp 0/0", value1, query1);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        issue(1, 5, 0, 0); #1;
        n_tests++;
        if (issue_accept !== 1 || issue_tag !== 3'd1) begin
            n_fail++; $display("FAIL basic_issue got acc=%0d tag=%0d exp 1/1", issue_accept, issue_tag);
        end
        adv();
        idle(); alu_des_in = 1; alu_data = 32'h1234; #1; adv();
        idle(); #1;
        n_tests++;
        if (commit_valid !== 0) begin n_fail++; $display("FAIL basic_early got cv=%0d exp 0", commit_valid); end
        adv();
        idle(); issue_rs1 = 5; #1;
        n_tests++;
        if (commit_valid !== 1 || commit_tag !== 3'd1 || commit_rd !== 5'd5 || commit_data !== 32'h1234) begin
            n_fail++; $display("FAIL basic_commit got v=%0d t=%0d rd=%0d d=%h exp 1/1/5/1234", commit_valid, commit_tag, commit_rd, commit_data);
        end
        adv();
        idle(); issue_rs1 = 5; #1;
        n_tests++;
        if (value1 !== 32'h1234 || query1 !== 0 || commit_valid !== 0) begin
            n_fail++; $display("FAIL basic_readback got v=%h q=%0d cv=%0d exp 1234/0/0", value1, query1, commit_valid);
        end
        adv();
    endtask

    task automatic test_forward();
        do_reset();
        issue(1, 3, 0, 0); #1; adv();
        idle(); issue_rs1 = 3; #1;
        n_tests++;
        if (query1 !== 3'd1 || value1 !== 0) begin
            n_fail++; $display("FAIL fwd_pending got q=%0d v=%h exp 1/0", query1, value1);
        end
        adv();
        idle(); issue_rs1 = 3; alu_des_in = 1; alu_data = 32'hAA; #1;
        n_tests++;
        if (query1 !== 0 || value1 !== 32'hAA) begin
            n_fail++; $display("FAIL fwd_bypass got q=%0d v=%h exp 0/aa", query1, value1);
        end
        adv();
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue(1, 4, 0, 0); #1; adv();
        issue(1, 4, 4, 4); #1;
        n_tests++;
        if (query1 !== 3'd1 || query2 !== 3'd1 || issue_tag !== 3'd2) begin
            n_fail++; $display("FAIL same_cycle_old got q1=%0d q2=%0d tag=%0d exp 1/1/2", query1, query2, issue_tag);
        end
        adv();
        idle(); issue_rs1 = 4; #1;
        n_tests++;
        if (query1 !== 3'd2) begin n_fail++; $display("FAIL same_cycle_new got q=%0d exp 2", query1); end
        adv();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue(1, 5'(i + 1), 0, 0); #1;
            n_tests++;
            if (issue_accept !== 1 || issue_tag !== 3'(i + 1)) begin
                n_fail++; $display("FAIL fill_%0d got acc=%0d tag=%0d exp 1/%0d", i, issue_accept, issue_tag, i + 1);
            end
            adv();
        end
        issue(1, 9, 0, 0); alu_des_in = 1; alu_data = 32'h77; #1;
        n_tests++;
        if (rob_full !== 1 || issue_accept !== 0) begin
            n_fail++; $display("FAIL full_block got full=%0d acc=%0d exp 1/0", rob_full, issue_accept);
        end
        adv();
        issue(1, 9, 0, 0); #1;
        n_tests++;
        if (rob_full !== 1 || issue_accept !== 0) begin
            n_fail++; $display("FAIL full_commit_cycle got full=%0d acc=%0d exp 1/0", rob_full, issue_accept);
        end
        adv();
        issue(1, 9, 0, 0); #1;
        n_tests++;
        if (rob_full !== 0 || issue_accept !== 1 || issue_tag !== 3'd1 || commit_tag !== 3'd1) begin
            n_fail++; $display("FAIL wrap got full=%0d acc=%0d tag=%0d ctag=%0d exp 0/1/1/1", rob_full, issue_accept, issue_tag, commit_tag);
        end
        adv();
        idle(); #1;
        n_tests++;
        if (rob_full !== 1) begin n_fail++; $display("FAIL refill got full=%0d exp 1", rob_full); end
        adv();
    endtask

    task automatic test_ooo();
        do_reset();
        issue(1, 1, 0, 0); adv();
        issue(1, 2, 0, 0); adv();
        idle(); alu_des_in = 2; alu_data = 32'h22; adv();
        for (int i = 0; i < 3; i++) begin
            idle(); #1;
            n_tests++;
            if (commit_valid !== 0) begin n_fail++; $display("FAIL ooo_wait_%0d got cv=%0d exp 0", i, commit_valid); end
            adv();
        end
        idle(); alu_des_in = 1; alu_data = 32'h11; memory_des_in = 1; memory_data = 32'h55; issue_rs1 = 1; #1;
        n_tests++;
        if (value1 !== 32'h55 || query1 !== 0) begin
            n_fail++; $display("FAIL tie_bypass got v=%h q=%0d exp 55/0", value1, query1);
        end
        adv();
        idle(); #1; adv();
        idle(); #1;
        n_tests++;
        if (commit_valid !== 1 || commit_tag !== 3'd1 || commit_data !== 32'h55) begin
            n_fail++; $display("FAIL ooo_c1 got v=%0d t=%0d d=%h exp 1/1/55", commit_valid, commit_tag, commit_data);
        end
        adv();
        idle(); #1;
        n_tests++;
        if (commit_valid !== 1 || commit_tag !== 3'd2 || commit_data !== 32'h22) begin
            n_fail++; $display("FAIL ooo_c2 got v=%0d t=%0d d=%h exp 1/2/22", commit_valid, commit_tag, commit_data);
        end
        adv();
    endtask

    task automatic test_store();
        do_reset();
        issue(1, 7, 0, 0); adv();
        issue(27, 7, 0, 0); adv();
        idle(); issue_rs1 = 7; #1;
        n_tests++;
        if (query1 !== 3'd1) begin n_fail++; $display("FAIL store_norename got q=%0d exp 1", query1); end
        adv();
        idle(); alu_des_in = 1; alu_data = 32'h77; memory_des_in = 2; memory_data = 32'h99; adv();
        idle(); adv();
        idle(); #1; adv();
        idle(); issue_rs1 = 7; #1;
        n_tests++;
        if (commit_valid !== 1 || commit_tag !== 3'd2 || commit_rd !== 0 || value1 !== 32'h77 || query1 !== 0) begin
            n_fail++; $display("FAIL store_commit got v=%0d t=%0d rd=%0d r7=%h q=%0d exp 1/2/0/77/0",
                               commit_valid, commit_tag, commit_rd, value1, query1);
        end
        adv();
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 1, 0, 0); adv();
        idle(); alu_des_in = 1; alu_data = 32'hF1; adv();
        idle(); adv();
        for (int i = 1; i <= 4; i++) begin issue(1, 5'(i), 0, 0); adv(); end
        idle(); alu_des_in = 2; alu_data = 32'hBB; adv();
        issue(1, 6, 0, 0); flush = 1; #1;
        n_tests++;
        if (issue_accept !== 0) begin n_fail++; $display("FAIL flush_block got acc=%0d exp 0", issue_accept); end
        adv();
        idle(); issue_rs1 = 1; issue_rs2 = 2; #1;
        n_tests++;
        if (commit_valid !== 0 || rob_full !== 0 || issue_tag !== 3'd1) begin
            n_fail++; $display("FAIL flush_state got cv=%0d full=%0d tag=%0d exp 0/0/1", commit_valid, rob_full, issue_tag);
        end
        n_tests++;
        if (value1 !== 32'hF1 || query1 !== 0 || value2 !== 0 || query2 !== 0) begin
            n_fail++; $display("FAIL flush_lookup got v1=%h q1=%0d v2=%h q2=%0d exp f1/0/0/0", value1, query1, value2, query2);
        end
        adv();
        idle(); #1;
        n_tests++;
        if (commit_valid !== 0) begin n_fail++; $display("FAIL flush_nocommit got cv=%0d exp 0", commit_valid); end
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin issue(1, 5'(i), 0, 0); adv(); end
        idle(); alu_des_in = 1; alu_data = 32'h5; adv();
        #2;
        idle(); rst = 1; issue_rs1 = 1; #1;
        n_tests++;
        if (commit_valid !== 0 || rob_full !== 0 || issue_tag !== 3'd1 || value1 !== 0 || query1 !== 0) begin
            n_fail++; $display("FAIL midreset got cv=%0d full=%0d tag=%0d v=%h q=%0d exp 0/0/1/0/0",
                               commit_valid, rob_full, issue_tag, value1, query1);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        issue(1, 2, 0, 0); #1;
        n_tests++;
        if (issue_accept !== 1 || issue_tag !== 3'd1) begin
            n_fail++; $display("FAIL post_reset_issue got acc=%0d tag=%0d exp 1/1", issue_accept, issue_tag);
        end
        adv();
        idle(); #1;
        n_tests++;
        if (commit_valid !== 0 || issue_tag !== 3'd2) begin
            n_fail++; $display("FAIL release_edge got cv=%0d tag=%0d exp 0/2", commit_valid, issue_tag);
        end
        adv();
    endtask

    task automatic test_random();
        logic [31:0] ev1, ev2;
        logic [2:0]  eq1, eq2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_op    = 6'($urandom_range(0, 31));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            rs_full     = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            alu_data    = $urandom;
            memory_data = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 2) != 0)
                alu_des_in = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                alu_des_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) memory_des_in = alu_des_in;
            else if (mq.size() > 0 && $urandom_range(0, 1) != 0)
                memory_des_in = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                memory_des_in = 3'($urandom_range(0, 7));
            #1;
            m_lookup(issue_rs1, ev1, eq1);
            m_lookup(issue_rs2, ev2, eq2);
            n_tests++;
            if (issue_accept !== m_accept() || issue_tag !== m_tail || rob_full !== (mq.size() == 7)) begin
                n_fail++; $display("FAIL rnd_issue cyc%0d got acc=%0d tag=%0d full=%0d exp %0d/%0d/%0d",
                                   cyc, issue_accept, issue_tag, rob_full, m_accept(), m_tail, mq.size() == 7);
            end
            n_tests++;
            if (value1 !== ev1 || query1 !== eq1 || value2 !== ev2 || query2 !== eq2) begin
                n_fail++; $display("FAIL rnd_lookup cyc%0d got %h/%0d %h/%0d exp %h/%0d %h/%0d",
                                   cyc, value1, query1, value2, query2, ev1, eq1, ev2, eq2);
            end
            n_tests++;
            if (commit_valid !== m_cv || (m_cv && (commit_tag !== m_ctag || commit_rd !== m_crd || commit_data !== m_cdata))) begin
                n_fail++; $display("FAIL rnd_commit cyc%0d got %0d t=%0d rd=%0d d=%h exp %0d t=%0d rd=%0d d=%h",
                                   cyc, commit_valid, commit_tag, commit_rd, commit_data, m_cv, m_ctag, m_crd, m_cdata);
            end
            adv();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_same_cycle();
        test_full_wrap();
        test_ooo();
        test_store();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
